// File: rtl/mips_pkg.sv
// Shared definitions for the multi-cycle MIPS core: opcode/funct encodings,
// FSM state and ALU operation enums, and the ALU evaluation function.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_JR    = 6'h08;
  localparam logic [5:0] FN_ADDU  = 6'h21;
  localparam logic [5:0] FN_SUBU  = 6'h23;
  localparam logic [5:0] FN_AND   = 6'h24;
  localparam logic [5:0] FN_OR    = 6'h25;
  localparam logic [5:0] FN_SLT   = 6'h2A;
  localparam logic [5:0] FN_SLTU  = 6'h2B;

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
  } state_t;

  typedef enum logic [2:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT, ALU_SLTU, ALU_LUI
  } alu_op_t;

  // 32-bit wrapping ALU; no overflow detection.
  function automatic logic [31:0] alu_eval(input alu_op_t op, input logic [31:0] a,
                                           input logic [31:0] b);
    logic signed [31:0] sa;
    logic signed [31:0] sb;
    sa = signed'(a);
    sb = signed'(b);
    case (op)
      ALU_ADD:  return a + b;
      ALU_SUB:  return a - b;
      ALU_AND:  return a & b;
      ALU_OR:   return a | b;
      ALU_SLT:  return {31'd0, (sa < sb)};
      ALU_SLTU: return {31'd0, (a < b)};
      ALU_LUI:  return {b[15:0], 16'h0000};
      default:  return '0;
    endcase
  endfunction

endpackage

// File: rtl/mips_multicycle_core_if.sv
// Instruction and data memory req/ready bus between the core (master) and memories (slave).
interface mips_multicycle_core_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic        dmem_ready;
  logic [31:0] dmem_rdata;

  modport master (
    output imem_req, imem_addr, dmem_req, dmem_we, dmem_addr, dmem_wdata,
    input  imem_ready, imem_rdata, dmem_ready, dmem_rdata
  );

  modport slave (
    input  imem_req, imem_addr, dmem_req, dmem_we, dmem_addr, dmem_wdata,
    output imem_ready, imem_rdata, dmem_ready, dmem_rdata
  );
endinterface

// File: rtl/mips_regfile.sv
// 32x32 register file: two asynchronous reads, one synchronous write, $0 reads as zero.
module mips_regfile #(
  parameter bit REG_INIT_ZERO = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  raddr1_i,
  input  logic [4:0]  raddr2_i,
  output logic [31:0] rdata1_o,
  output logic [31:0] rdata2_o,
  input  logic        we_i,
  input  logic [4:0]  waddr_i,
  input  logic [31:0] wdata_i
);

  logic [31:0] regs_q [32];

  always_ff @(posedge clk) begin
    if (reset && REG_INIT_ZERO) begin
      for (int i = 0; i < 32; i++) regs_q[i] <= '0;
    end else if (we_i && waddr_i != 5'd0) begin
      regs_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata1_o = (raddr1_i == 5'd0) ? '0 : regs_q[raddr1_i];
  assign rdata2_o = (raddr2_i == 5'd0) ? '0 : regs_q[raddr2_i];

endmodule

// File: rtl/mips_multicycle_core.sv
// Multi-cycle MIPS core: one FSM sequences fetch/decode/execute/memory/writeback
// over req/ready memory ports, so either memory may stall for any number of cycles.
module mips_multicycle_core
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC        = 32'h0000_0000,
  parameter bit          HALT_ON_ILLEGAL = 1'b1,
  parameter bit          REG_INIT_ZERO   = 1'b1
) (
  input  logic                          clk,
  input  logic                          reset,
  mips_multicycle_core_if.master        bus,
  output logic [31:0]                   pc,
  output logic                          retire,
  output logic                          halted
);

  state_t      state_q;
  logic [31:0] pc_q, ir_q, a_q, b_q, imm_q, aluout_q, mdr_q;
  logic        retire_q;

  logic [5:0]  op, fn;
  logic [4:0]  rs, rt, rd;
  logic [15:0] imm16;
  assign op    = ir_q[31:26];
  assign rs    = ir_q[25:21];
  assign rt    = ir_q[20:16];
  assign rd    = ir_q[15:11];
  assign imm16 = ir_q[15:0];
  assign fn    = ir_q[5:0];

  logic        legal, zext_imm;
  alu_op_t     alu_op;
  always_comb begin
    legal    = 1'b1;
    zext_imm = 1'b0;
    alu_op   = ALU_ADD;
    case (op)
      OP_RTYPE: begin
        case (fn)
          FN_ADDU: alu_op = ALU_ADD;
          FN_SUBU: alu_op = ALU_SUB;
          FN_AND:  alu_op = ALU_AND;
          FN_OR:   alu_op = ALU_OR;
          FN_SLT:  alu_op = ALU_SLT;
          FN_SLTU: alu_op = ALU_SLTU;
          FN_JR:   alu_op = ALU_ADD;
          default: legal  = 1'b0;
        endcase
      end
      OP_ADDIU, OP_LW, OP_SW: alu_op = ALU_ADD;
      OP_SLTI: alu_op = ALU_SLT;
      OP_ANDI: begin alu_op = ALU_AND; zext_imm = 1'b1; end
      OP_ORI:  begin alu_op = ALU_OR;  zext_imm = 1'b1; end
      OP_LUI:  alu_op = ALU_LUI;
      OP_J, OP_JAL, OP_BEQ, OP_BNE: alu_op = ALU_ADD;
      default: legal = 1'b0;
    endcase
  end

  logic [31:0] rf_rd1, rf_rd2, imm_ext, alu_b, aluout_d, pc4, br_tgt, j_tgt;
  logic        br_taken, exec_fault;
  assign imm_ext  = zext_imm ? {16'h0000, imm16} : {{16{imm16[15]}}, imm16};
  assign alu_b    = (op == OP_RTYPE) ? b_q : imm_q;
  assign aluout_d = alu_eval(alu_op, a_q, alu_b);
  assign pc4      = pc_q + 32'd4;
  assign br_tgt   = pc4 + {imm_q[29:0], 2'b00};
  assign j_tgt    = {pc4[31:28], ir_q[25:0], 2'b00};
  assign br_taken = (a_q == b_q) ^ (op == OP_BNE);
  // Misaligned data addresses and jr targets are faults discovered only once A is known.
  assign exec_fault = ((op == OP_LW || op == OP_SW) && aluout_d[1:0] != 2'b00) ||
                      (op == OP_RTYPE && fn == FN_JR && a_q[1:0] != 2'b00);

  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  always_comb begin
    rf_we    = 1'b0;
    rf_waddr = rd;
    rf_wdata = aluout_q;
    if (!reset) begin
      if (state_q == S_WB) begin
        rf_we    = 1'b1;
        rf_waddr = (op == OP_RTYPE) ? rd : rt;
        rf_wdata = (op == OP_LW) ? mdr_q : aluout_q;
      end else if (state_q == S_EXEC && op == OP_JAL && !exec_fault) begin
        rf_we    = 1'b1;
        rf_waddr = 5'd31;
        rf_wdata = pc4;
      end
    end
  end

  mips_regfile #(.REG_INIT_ZERO(REG_INIT_ZERO)) u_rf (
    .clk      (clk),
    .reset    (reset),
    .raddr1_i (rs),
    .raddr2_i (rt),
    .rdata1_o (rf_rd1),
    .rdata2_o (rf_rd2),
    .we_i     (rf_we),
    .waddr_i  (rf_waddr),
    .wdata_i  (rf_wdata)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_FETCH;
      pc_q     <= RESET_PC;
      ir_q     <= '0;
      retire_q <= 1'b0;
    end else begin
      retire_q <= 1'b0;
      case (state_q)
        S_FETCH: begin
          if (bus.imem_ready) begin
            ir_q    <= bus.imem_rdata;
            state_q <= S_DECODE;
          end
        end
        S_DECODE: begin
          a_q   <= rf_rd1;
          b_q   <= rf_rd2;
          imm_q <= imm_ext;
          if (legal) begin
            state_q <= S_EXEC;
          end else if (HALT_ON_ILLEGAL) begin
            state_q <= S_HALT;
          end else begin
            pc_q     <= pc4;
            retire_q <= 1'b1;
            state_q  <= S_FETCH;
          end
        end
        S_EXEC: begin
          aluout_q <= aluout_d;
          if (exec_fault) begin
            if (HALT_ON_ILLEGAL) begin
              state_q <= S_HALT;
            end else begin
              pc_q     <= pc4;
              retire_q <= 1'b1;
              state_q  <= S_FETCH;
            end
          end else begin
            case (op)
              OP_LW, OP_SW: state_q <= S_MEM;
              OP_BEQ, OP_BNE: begin
                pc_q     <= br_taken ? br_tgt : pc4;
                retire_q <= 1'b1;
                state_q  <= S_FETCH;
              end
              OP_J, OP_JAL: begin
                pc_q     <= j_tgt;
                retire_q <= 1'b1;
                state_q  <= S_FETCH;
              end
              OP_RTYPE: begin
                if (fn == FN_JR) begin
                  pc_q     <= a_q;
                  retire_q <= 1'b1;
                  state_q  <= S_FETCH;
                end else begin
                  state_q <= S_WB;
                end
              end
              default: state_q <= S_WB;
            endcase
          end
        end
        S_MEM: begin
          if (bus.dmem_ready) begin
            if (op == OP_SW) begin
              pc_q     <= pc4;
              retire_q <= 1'b1;
              state_q  <= S_FETCH;
            end else begin
              mdr_q   <= bus.dmem_rdata;
              state_q <= S_WB;
            end
          end
        end
        S_WB: begin
          pc_q     <= pc4;
          retire_q <= 1'b1;
          state_q  <= S_FETCH;
        end
        S_HALT: state_q <= S_HALT;
        default: state_q <= S_FETCH;
      endcase
    end
  end

  // Bus strobes decode straight from the state register so they track it cycle for cycle.
  assign bus.imem_req   = (state_q == S_FETCH);
  assign bus.imem_addr  = pc_q;
  assign bus.dmem_req   = (state_q == S_MEM);
  assign bus.dmem_we    = (state_q == S_MEM) && (op == OP_SW);
  assign bus.dmem_addr  = aluout_q;
  assign bus.dmem_wdata = b_q;
  assign pc             = pc_q;
  assign retire         = retire_q;
  assign halted         = (state_q == S_HALT);

endmodule

// File: tb/tb_mips_multicycle_core.sv
// Randomized and directed bench for mips_multicycle_core against an instruction-level reference model.
module tb_mips_multicycle_core;

  localparam logic [31:0] RST_PC  = 32'h0000_0400;
  localparam logic [31:0] ILLEGAL = 32'hFC00_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] pc;
  logic        retire, halted;

  mips_multicycle_core_if bus();

  mips_multicycle_core #(
    .RESET_PC(RST_PC), .HALT_ON_ILLEGAL(1'b1), .REG_INIT_ZERO(1'b1)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus.master), .pc(pc), .retire(retire), .halted(halted)
  );

  always #5 clk = ~clk;

  logic [31:0] imem   [1024];
  logic [31:0] dmem   [64];
  logic [31:0] m_dmem [64];
  logic [31:0] m_reg  [32];
  logic [31:0] m_pc;
  int n_cmp = 0;
  int n_mis = 0;

  int ifrc = -1, dfrc = -1, iwait = 0, dwait = 0, icnt = 0, dcnt = 0;
  bit          st_seen;
  logic [31:0] st_addr, st_data;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int pick(input int frc);
    return (frc >= 0) ? frc : int'($urandom_range(0, 2));
  endfunction

  task automatic set_waits(input int i, input int d);
    ifrc = i; dfrc = d; iwait = pick(i); dwait = pick(d);
  endtask

  // Memory responders: ready is raised for one cycle after the chosen number of wait cycles.
  initial begin
    bus.imem_ready = 1'b0; bus.imem_rdata = '0;
    bus.dmem_ready = 1'b0; bus.dmem_rdata = '0;
    forever begin
      @(negedge clk);
      if (bus.imem_ready) bus.imem_ready = 1'b0;
      else if (!bus.imem_req || reset) icnt = 0;
      else if (icnt >= iwait) begin
        bus.imem_ready = 1'b1;
        bus.imem_rdata = imem[bus.imem_addr[11:2]];
        icnt = 0; iwait = pick(ifrc);
      end else icnt++;
      if (bus.dmem_ready) bus.dmem_ready = 1'b0;
      else if (!bus.dmem_req || reset) dcnt = 0;
      else if (dcnt >= dwait) begin
        bus.dmem_ready = 1'b1;
        if (bus.dmem_we) begin
          dmem[bus.dmem_addr[7:2]] = bus.dmem_wdata;
          st_seen = 1'b1; st_addr = bus.dmem_addr; st_data = bus.dmem_wdata;
        end else begin
          bus.dmem_rdata = dmem[bus.dmem_addr[7:2]];
        end
        dcnt = 0; dwait = pick(dfrc);
      end else dcnt++;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] r_ins(input logic [5:0] fn, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [4:0] rd);
    return {6'h00, rs, rt, rd, 5'h00, fn};
  endfunction
  function automatic logic [31:0] i_ins(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  task automatic do_reset();
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    m_pc = RST_PC;
    for (int i = 0; i < 32; i++) m_reg[i] = '0;
  endtask

  task automatic init_dmem();
    for (int i = 0; i < 64; i++) begin
      dmem[i] = $urandom;
      m_dmem[i] = dmem[i];
    end
  endtask

  // Executes one instruction architecturally; reports the register written and any store.
  task automatic mdl_step(output bit halt, output int wreg, output bit is_st,
                          output logic [31:0] sa, output logic [31:0] sd);
    logic [31:0] ins, rsv, rtv, se, ze, pc4, nxt, val, ea;
    ins = imem[m_pc[11:2]];
    rsv = m_reg[ins[25:21]];
    rtv = m_reg[ins[20:16]];
    se  = {{16{ins[15]}}, ins[15:0]};
    ze  = {16'h0000, ins[15:0]};
    pc4 = m_pc + 32'd4;
    nxt = pc4; halt = 1'b0; wreg = 0; val = '0; is_st = 1'b0; sa = '0; sd = '0;
    ea  = rsv + se;
    case (ins[31:26])
      6'h00: begin
        wreg = int'(ins[15:11]);
        case (ins[5:0])
          6'h21: val = rsv + rtv;
          6'h23: val = rsv - rtv;
          6'h24: val = rsv & rtv;
          6'h25: val = rsv | rtv;
          6'h2A: val = ($signed(rsv) < $signed(rtv)) ? 32'd1 : 32'd0;
          6'h2B: val = (rsv < rtv) ? 32'd1 : 32'd0;
          6'h08: begin wreg = 0; if (rsv[1:0] != 2'b00) halt = 1'b1; else nxt = rsv; end
          default: halt = 1'b1;
        endcase
      end
      6'h09: begin wreg = int'(ins[20:16]); val = rsv + se; end
      6'h0A: begin wreg = int'(ins[20:16]); val = ($signed(rsv) < $signed(se)) ? 32'd1 : 32'd0; end
      6'h0C: begin wreg = int'(ins[20:16]); val = rsv & ze; end
      6'h0D: begin wreg = int'(ins[20:16]); val = rsv | ze; end
      6'h0F: begin wreg = int'(ins[20:16]); val = {ins[15:0], 16'h0000}; end
      6'h23: begin
        if (ea[1:0] != 2'b00) halt = 1'b1;
        else begin wreg = int'(ins[20:16]); val = m_dmem[ea[7:2]]; end
      end
      6'h2B: begin
        if (ea[1:0] != 2'b00) halt = 1'b1;
        else begin is_st = 1'b1; sa = ea; sd = rtv; m_dmem[ea[7:2]] = rtv; end
      end
      6'h04: if (rsv == rtv) nxt = pc4 + (se << 2);
      6'h05: if (rsv != rtv) nxt = pc4 + (se << 2);
      6'h02: nxt = {pc4[31:28], ins[25:0], 2'b00};
      6'h03: begin nxt = {pc4[31:28], ins[25:0], 2'b00}; wreg = 31; val = pc4; end
      default: halt = 1'b1;
    endcase
    if (halt) wreg = 0;
    else begin
      if (wreg != 0) m_reg[wreg] = val;
      m_pc = nxt;
    end
  endtask

  // Runs up to n instructions in lockstep with the model, stopping at a halt.
  task automatic run(input int n);
    bit halt, is_st, ok;
    int wreg, rcnt;
    logic [31:0] sa, sd;
    for (int k = 0; k < n; k++) begin
      st_seen = 1'b0;
      mdl_step(halt, wreg, is_st, sa, sd);
      ok = 1'b0;
      for (int c = 0; c < 100; c++) begin
        @(negedge clk);
        if ((halt && halted) || (!halt && retire)) begin ok = 1'b1; break; end
      end
      if (halt) begin
        chk("halt_seen", 32'(ok), 32'd1);
        if (!ok) return;
        chk("halt_pc", pc, m_pc);
        rcnt = 0;
        for (int c = 0; c < 4; c++) begin
          @(negedge clk);
          if (retire) rcnt++;
          if (bus.imem_req || bus.dmem_req) rcnt += 16;
        end
        chk("halt_quiet", 32'(rcnt), 32'd0);
        chk("halt_hold", 32'(halted), 32'd1);
        return;
      end
      chk("retire_seen", 32'(ok), 32'd1);
      if (!ok) return;
      chk("pc", pc, m_pc);
      if (wreg != 0) chk($sformatf("r%0d", wreg), dut.u_rf.regs_q[wreg], m_reg[wreg]);
      if (is_st) begin
        chk("st_seen", 32'(st_seen), 32'd1);
        chk("st_addr", st_addr, sa);
        chk("st_data", st_data, sd);
      end
    end
  endtask

  task automatic gen_prog(input int len);
    int kind;
    logic [4:0]  rs, rt, rd;
    logic [15:0] imm;
    logic [31:0] ins;
    for (int i = 0; i < len; i++) begin
      kind = int'($urandom_range(0, 14));
      rs = 5'($urandom_range(0, 7));
      rt = 5'($urandom_range(0, 7));
      rd = 5'($urandom_range(0, 7));
      imm = 16'($urandom);
      case (kind)
        0:  ins = r_ins(6'h21, rs, rt, rd);
        1:  ins = r_ins(6'h23, rs, rt, rd);
        2:  ins = r_ins(6'h24, rs, rt, rd);
        3:  ins = r_ins(6'h25, rs, rt, rd);
        4:  ins = r_ins(6'h2A, rs, rt, rd);
        5:  ins = r_ins(6'h2B, rs, rt, rd);
        6:  ins = i_ins(6'h09, rs, rt, imm);
        7:  ins = i_ins(6'h0A, rs, rt, imm);
        8:  ins = i_ins(6'h0C, rs, rt, imm);
        9:  ins = i_ins(6'h0D, rs, rt, imm);
        10: ins = i_ins(6'h0F, 5'd0, rt, imm);
        11: ins = i_ins(6'h23, 5'd0, rt, 16'($urandom_range(0, 63) * 4));
        12: ins = i_ins(6'h2B, 5'd0, rt, 16'($urandom_range(0, 63) * 4));
        13: ins = i_ins(6'h04, rs, rt, 16'($urandom_range(0, 2)));
        default: ins = i_ins(6'h05, rs, rt, 16'($urandom_range(0, 2)));
      endcase
      imem[256 + i] = ins;
    end
    for (int i = len; i < len + 4; i++) imem[256 + i] = ILLEGAL;
  endtask

  initial begin
    bit ok;
    for (int i = 0; i < 1024; i++) imem[i] = ILLEGAL;
    init_dmem();

    // Directed program: stalled fetch, store/load, branches, jal/jr, self-loop.
    imem[256] = i_ins(6'h09, 5'd0, 5'd1, 16'd5);
    imem[257] = i_ins(6'h2B, 5'd0, 5'd1, 16'd8);
    imem[258] = i_ins(6'h23, 5'd0, 5'd2, 16'd8);
    imem[259] = i_ins(6'h05, 5'd1, 5'd2, 16'd3);
    imem[260] = {6'h03, 26'h40};
    imem[64]  = r_ins(6'h08, 5'd31, 5'd0, 5'd0);
    imem[261] = i_ins(6'h04, 5'd1, 5'd1, 16'hFFFF);
    set_waits(3, 2);
    do_reset();
    chk("rst_ireq", 32'(bus.imem_req), 32'd1);
    chk("rst_iaddr", bus.imem_addr, RST_PC);
    chk("rst_retire", 32'(retire), 32'd0);
    chk("rst_halted", 32'(halted), 32'd0);
    chk("rst_dreq", 32'(bus.dmem_req), 32'd0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("stall_ireq", 32'(bus.imem_req), 32'd1);
      chk("stall_iaddr", bus.imem_addr, RST_PC);
      chk("stall_retire", 32'(retire), 32'd0);
    end
    ifrc = -1;
    run(3);
    dfrc = -1;
    run(5);
    chk("loop_pc", pc, 32'h0000_0414);

    // Reset while a load is stuck waiting for dmem_ready.
    for (int i = 0; i < 1024; i++) imem[i] = ILLEGAL;
    imem[256] = i_ins(6'h23, 5'd0, 5'd3, 16'd0);
    dmem[0] = 32'hCAFE_0001; m_dmem[0] = 32'hCAFE_0001;
    set_waits(-1, 1000);
    do_reset();
    ok = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (bus.dmem_req) begin ok = 1'b1; break; end
    end
    chk("memwait_req", 32'(ok), 32'd1);
    chk("memwait_we", 32'(bus.dmem_we), 32'd0);
    @(negedge clk);
    do_reset();
    chk("rstmem_dreq", 32'(bus.dmem_req), 32'd0);
    chk("rstmem_ireq", 32'(bus.imem_req), 32'd1);
    chk("rstmem_pc", pc, RST_PC);
    chk("rstmem_retire", 32'(retire), 32'd0);
    chk("rstmem_r3", dut.u_rf.regs_q[3], 32'd0);
    set_waits(-1, -1);
    run(1);

    // Illegal opcode halts; reset resumes fetch.
    imem[256] = ILLEGAL;
    do_reset();
    run(2);
    do_reset();
    chk("resume_ireq", 32'(bus.imem_req), 32'd1);
    chk("resume_iaddr", bus.imem_addr, RST_PC);
    chk("resume_halted", 32'(halted), 32'd0);

    // Misaligned load address and misaligned jr target halt at the faulting pc.
    imem[256] = i_ins(6'h23, 5'd0, 5'd4, 16'd2);
    do_reset();
    run(2);
    imem[256] = i_ins(6'h09, 5'd0, 5'd6, 16'h0402);
    imem[257] = r_ins(6'h08, 5'd6, 5'd0, 5'd0);
    do_reset();
    run(3);

    // Random programs, each terminated by illegal words.
    for (int p = 0; p < 6; p++) begin
      for (int i = 0; i < 1024; i++) imem[i] = ILLEGAL;
      gen_prog(32);
      init_dmem();
      do_reset();
      run(40);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
